// File: rtl/jtbubl_romslot.sv
`default_nettype none
// ============================================================================
//  Module   : jtbubl_romslot
//  Purpose  : One SDRAM read slot for a ROM client, with a single 32-bit word
//             cache so that sequential fetches inside a word skip the SDRAM.
//  Revision : 1.0  initial release
// ============================================================================
module jtbubl_romslot #(
    parameter int          AW     = 18,
    parameter int          DW     = 8,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dout,
    output logic          ok,
    output logic [21:0]   sdram_addr,
    output logic          req,
    input  logic          ack,
    input  logic          data_rdy,
    input  logic [31:0]   data_read
);

    // Number of client address bits that select a lane inside the cached word
    localparam int c_LSB = (DW == 8) ? 2 : (DW == 16) ? 1 : 0;
    localparam int c_TW  = AW - c_LSB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_TW-1:0] r_tag;
    logic [c_TW-1:0] w_tag;
    logic [c_TW:0]   w_tag_x2;
    logic [21:0]     w_sdram_nxt;
    logic [31:0]     r_cache;
    logic            r_valid;
    logic            w_hit;
    logic            w_start;
    logic            w_fill;

    assign w_tag       = addr[AW-1:c_LSB];
    assign w_tag_x2    = {w_tag, 1'b0};
    assign w_sdram_nxt = OFFSET + 22'(w_tag_x2);   // wraps modulo 2^22

    assign w_hit = r_valid && (r_tag == w_tag);
    assign ok    = cs && w_hit && (r_state == ST_IDLE) && !downloading;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_fill      = 1'b0;
        if (downloading) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cs && !w_hit) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    // data_rdy alongside ack counts as ack followed by data
                    if (ack) begin
                        if (data_rdy) begin
                            w_fill      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        w_fill      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tag      <= '0;
            r_cache    <= '0;
            r_valid    <= 1'b0;
            sdram_addr <= '0;
            req        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (downloading) begin
                r_valid <= 1'b0;
                req     <= 1'b0;
            end else begin
                if (w_start) begin
                    // The cache word no longer belongs to the new tag until refilled
                    r_tag      <= w_tag;
                    sdram_addr <= w_sdram_nxt;
                    req        <= 1'b1;
                    r_valid    <= 1'b0;
                end else if ((r_state == ST_REQ) && ack) begin
                    req <= 1'b0;
                end
                if (w_fill) begin
                    r_cache <= data_read;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    if (DW == 8) begin : g_dw8
        assign dout = r_cache[{addr[1:0], 3'b000} +: 8];
    end else if (DW == 16) begin : g_dw16
        assign dout = r_cache[{addr[0], 4'b0000} +: 16];
    end else begin : g_dw32
        assign dout = r_cache[DW-1:0];
    end

endmodule
`default_nettype wire

// File: tb/tb_jtbubl_romslot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtbubl_romslot
//  Purpose  : Directed bench for jtbubl_romslot (DW=8) with a queued
//             scoreboard of expected request addresses and hit data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtbubl_romslot;

    localparam int          AW    = 18;
    localparam int          DW    = 8;
    localparam logic [21:0] c_OFS = 22'h14000;
    localparam int          K_REQ = 0;
    localparam int          K_OK  = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          downloading = 1'b0;
    logic          cs = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          ack = 1'b0;
    logic          data_rdy = 1'b0;
    logic [31:0]   data_read = '0;
    logic [DW-1:0] dout, dout_w;
    logic          ok, ok_w, req, req_w;
    logic [21:0]   sdram_addr, sdram_addr_w;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    jtbubl_romslot #(.AW(AW), .DW(DW), .OFFSET(c_OFS)) dut (
        .clk(clk), .rst(rst), .downloading(downloading), .cs(cs), .addr(addr),
        .dout(dout), .ok(ok), .sdram_addr(sdram_addr), .req(req),
        .ack(ack), .data_rdy(data_rdy), .data_read(data_read)
    );

    // Same stimulus, base address near the top of SDRAM to exercise wrapping
    jtbubl_romslot #(.AW(AW), .DW(DW), .OFFSET(22'h3FFFFE)) dut_w (
        .clk(clk), .rst(rst), .downloading(downloading), .cs(cs), .addr(addr),
        .dout(dout_w), .ok(ok_w), .sdram_addr(sdram_addr_w), .req(req_w),
        .ack(ack), .data_rdy(data_rdy), .data_read(data_read)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [31:0] act);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: kind %0d value %h, nothing expected", kind, act);
        end else begin
            e = q.pop_front();
            chk(kind == K_REQ ? "sb_kind_req" : "sb_kind_ok", 32'(kind), 32'(e.kind));
            chk(kind == K_REQ ? "sb_sdram_addr" : "sb_dout", act, e.val);
        end
    endtask

    // Monitor: a new request (req rising) or a hit presented for a new address
    logic          prev_req = 1'b0;
    logic          prev_ok  = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (req && !prev_req)
                pop_cmp(K_REQ, 32'(sdram_addr));
            if (ok && (!prev_ok || addr != prev_addr))
                pop_cmp(K_OK, 32'(dout));
        end
        prev_req  = req;
        prev_ok   = ok;
        prev_addr = addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!req && n < 20) begin
            tick();
            n++;
        end
        if (!req) chk("req_timeout", 32'(req), 32'd1);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse_data(input logic [31:0] d);
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_rdy  = 1'b0;
    endtask

    task automatic serve(input logic [31:0] d);
        int n;
        wait_req(n);
        chk("miss_latency", 32'(n), 32'd1);
        pulse_ack();
        tick();
        pulse_data(d);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick();
        tick();
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_ok", 32'(ok), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_sdram_addr", 32'(sdram_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Basic miss and fill at byte 4
        cs   = 1'b1;
        addr = 18'h00004;
        push(K_REQ, 32'h14002);
        push(K_OK, 32'hAA);
        #1 chk("t1_miss_ok", 32'(ok), 32'd0);
        serve(32'hDDCCBBAA);

        // Sequential bytes hit in the cached word
        for (int i = 5; i <= 7; i++) begin
            push(K_OK, 32'hAA + 32'h11 * 32'(i - 4));
            addr = AW'(i);
            #1 chk("t2_hit_ok", 32'(ok), 32'd1);
            chk("t2_hit_noreq", 32'(req), 32'd0);
            tick();
            chk("t2_hit_noreq_next", 32'(req), 32'd0);
        end
        addr = 18'h00008;
        push(K_REQ, 32'h14004);
        push(K_OK, 32'h11);
        #1 chk("t2_next_word_ok", 32'(ok), 32'd0);
        wait_req(n);
        chk("wrap_sdram_addr", 32'(sdram_addr_w), 32'h000002);
        pulse_ack();
        tick();
        pulse_data(32'h44332211);
        tick();

        // Address moves while a fill is in flight
        addr = 18'h00010;
        push(K_REQ, 32'h14008);
        wait_req(n);
        pulse_ack();
        addr = 18'h00040;
        push(K_REQ, 32'h14020);
        push(K_OK, 32'h88);
        tick();
        pulse_data(32'h0A0B0C0D);
        chk("t3_stale_ok", 32'(ok), 32'd0);
        serve(32'h55667788);

        // cs dropped mid-transaction, ack and data_rdy together
        addr = 18'h00020;
        push(K_REQ, 32'h14010);
        wait_req(n);
        cs = 1'b0;
        ack = 1'b1;
        data_rdy = 1'b1;
        data_read = 32'h99887766;
        tick();
        ack = 1'b0;
        data_rdy = 1'b0;
        chk("t4_nocs_ok", 32'(ok), 32'd0);
        tick();
        push(K_OK, 32'h66);
        cs = 1'b1;
        #1 chk("t4_recs_ok", 32'(ok), 32'd1);
        tick();
        chk("t4_recs_noreq", 32'(req), 32'd0);
        tick();

        // Download while waiting for data
        addr = 18'h00030;
        push(K_REQ, 32'h14018);
        wait_req(n);
        pulse_ack();
        downloading = 1'b1;
        tick();
        chk("t5_dl_req", 32'(req), 32'd0);
        chk("t5_dl_ok", 32'(ok), 32'd0);
        pulse_data(32'h12345678);
        chk("t5_discard_ok", 32'(ok), 32'd0);
        push(K_REQ, 32'h14018);
        push(K_OK, 32'hDD);
        downloading = 1'b0;
        serve(32'hAABBCCDD);

        // Asynchronous reset while requesting
        addr = 18'h00050;
        push(K_REQ, 32'h14028);
        wait_req(n);
        #6 rst = 1'b1;
        #1 chk("t6_async_req", 32'(req), 32'd0);
        chk("t6_async_ok", 32'(ok), 32'd0);
        tick();
        rst = 1'b0;
        #1 chk("t6_post_dout", 32'(dout), 32'd0);
        chk("t6_post_ok", 32'(ok), 32'd0);
        push(K_REQ, 32'h14028);
        push(K_OK, 32'h0C);
        serve(32'h0F0E0D0C);

        cs = 1'b0;
        tick();
        tick();
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
